// File: rtl/pll_rst_seq_pkg.sv
// pll_rst_seq_pkg: shared types and helpers for the PLL reset sequencer.
//   state_t    - 3-bit binary FSM encoding
//   max2       - larger of two unsigned values
//   cnt_width  - width of the shared cycle counter, covering every cycle parameter
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_RUN        = 3'd4,
    ST_STDBY      = 3'd5,
    ST_FAULT      = 3'd6
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // STABLE counts up to LOCK_STABLE inclusive, so the counter must hold the max value itself.
  function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                            input int unsigned lock_timeout,
                                            input int unsigned lock_stable,
                                            input int unsigned stage_gap);
    int unsigned m;
    m = max2(max2(rst_cycles, lock_timeout), max2(lock_stable, stage_gap));
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// pll_rst_seq_if: PLL-side and system-side signals of the reset sequencer.
//   pll_extlock  - PLL extlock (async to clk)
//   sleep_req    - standby request level (clk-synchronous)
//   clear_fault  - single-cycle pulse leaving FAULT
//   pll_reset    - PLL reset pin, active high
//   pll_stdby    - PLL standby pin
//   dom_rst_n    - per-domain active-low resets, bit 0 released first
//   locked       - sequencer in RUN
//   fault        - sequencer in FAULT
//   retry_cnt    - failed lock attempts since last RUN or clear
// master: the sequencer; slave: the PLL / system environment.
interface pll_rst_seq_if #(
  parameter int unsigned N_DOMAINS = 4,
  parameter int unsigned RETRY_W   = 2
);
  logic                 pll_extlock;
  logic                 sleep_req;
  logic                 clear_fault;
  logic                 pll_reset;
  logic                 pll_stdby;
  logic [N_DOMAINS-1:0] dom_rst_n;
  logic                 locked;
  logic                 fault;
  logic [RETRY_W-1:0]   retry_cnt;

  modport master (
    input  pll_extlock, sleep_req, clear_fault,
    output pll_reset, pll_stdby, dom_rst_n, locked, fault, retry_cnt
  );

  modport slave (
    output pll_extlock, sleep_req, clear_fault,
    input  pll_reset, pll_stdby, dom_rst_n, locked, fault, retry_cnt
  );
endinterface

// File: rtl/pll_rst_seq_sync.sv
// sync_2ff: generic 1-bit two-flop synchronizer, async active-low reset to 0.
//   clk, rst_n - destination clock and reset
//   d          - asynchronous input
//   q          - synchronized output (2 cycles latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: power-up, lock-supervision and staged reset-release sequencer
// for the system PLL. Runs on the PLL reference clock.
//   clk    - free-running reference clock (same net as PLL refclk)
//   rst_n  - asynchronous active-low reset
//   bus    - pll_rst_seq_if.master: extlock/sleep/clear in; PLL pins,
//            domain resets and status out (all outputs registered)
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned STAGE_GAP    = 16,
  parameter int unsigned N_DOMAINS    = 4,
  parameter int unsigned MAX_RETRY    = 3
) (
  input logic          clk,
  input logic          rst_n,
  pll_rst_seq_if.master bus
);

  localparam int unsigned CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, STAGE_GAP);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int unsigned STG_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_N  = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]   STG_LAST  = STG_W'(N_DOMAINS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [STG_W-1:0]     stg, stg_nxt;
  logic [RETRY_W-1:0]   retry, retry_nxt, retry_inc;
  logic [N_DOMAINS-1:0] dom_dec;
  logic                 lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pll_extlock),
    .q     (lock_s)
  );

  assign retry_inc = retry + RETRY_W'(1);

  // Priority: FAULT hold > sleep_req > lock loss > timeout > normal progress.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stg_nxt   = stg;
    retry_nxt = retry;
    if (state == ST_FAULT) begin
      if (bus.clear_fault) begin
        state_nxt = ST_RESET_HOLD;
        cnt_nxt   = '0;
        retry_nxt = '0;
      end
    end else if (bus.sleep_req) begin
      state_nxt = ST_STDBY;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_RESET_HOLD: begin
          if (cnt == RST_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            retry_nxt = retry_inc;
            state_nxt = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RESET_HOLD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STABLE_N) begin
            state_nxt = ST_RELEASE;
            cnt_nxt   = '0;
            stg_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            state_nxt = ST_RESET_HOLD;
            cnt_nxt   = '0;
          end else if (stg == STG_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end else if (cnt == GAP_LAST) begin
            stg_nxt = stg + STG_W'(1);
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt = ST_RESET_HOLD;
            cnt_nxt   = '0;
          end
        end
        ST_STDBY: begin
          // sleep_req is known low on this branch.
          state_nxt = ST_RESET_HOLD;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = ST_RESET_HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    dom_dec = '0;
    for (int unsigned i = 0; i < N_DOMAINS; i++) begin
      dom_dec[i] = (state_nxt == ST_RUN) ||
                   ((state_nxt == ST_RELEASE) && (i <= 32'(stg_nxt)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RESET_HOLD;
      cnt           <= '0;
      stg           <= '0;
      retry         <= '0;
      bus.pll_reset <= 1'b1;
      bus.pll_stdby <= 1'b0;
      bus.dom_rst_n <= '0;
      bus.locked    <= 1'b0;
      bus.fault     <= 1'b0;
      bus.retry_cnt <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      stg           <= stg_nxt;
      retry         <= retry_nxt;
      bus.pll_reset <= (state_nxt == ST_RESET_HOLD) || (state_nxt == ST_FAULT);
      bus.pll_stdby <= (state_nxt == ST_STDBY);
      bus.dom_rst_n <= dom_dec;
      bus.locked    <= (state_nxt == ST_RUN);
      bus.fault     <= (state_nxt == ST_FAULT);
      bus.retry_cnt <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed self-checking bench for pll_rst_seq.
// Parameters RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, STAGE_GAP=2,
// N_DOMAINS=4, MAX_RETRY=3. Time t counts falling clock edges after the
// first rst_n release; outputs are sampled on falling edges.
module tb_pll_rst_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned t = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  pll_rst_seq_if #(.N_DOMAINS(4), .RETRY_W(2)) ifc ();

  pll_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .STAGE_GAP    (2),
    .N_DOMAINS    (4),
    .MAX_RETRY    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  // {pll_reset, pll_stdby, dom_rst_n[3:0], locked, fault, retry_cnt[1:0]}
  function automatic logic [9:0] ev(input logic pr, input logic sb, input logic [3:0] d,
                                    input logic lk, input logic ft, input logic [1:0] rc);
    return {pr, sb, d, lk, ft, rc};
  endfunction

  task automatic chk(input string tag, input logic [9:0] expv);
    logic [9:0] obs;
    obs = {ifc.pll_reset, ifc.pll_stdby, ifc.dom_rst_n, ifc.locked, ifc.fault, ifc.retry_cnt};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %b expected %b", tag, t, obs, expv);
    end
  endtask

  task automatic step_to(input int unsigned target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    ifc.pll_extlock = 1'b1;
    ifc.sleep_req   = 1'b0;
    ifc.clear_fault = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_values", ev(1, 0, 4'b0000, 0, 0, 2'd0));
    rst_n = 1'b1;
    t = 0;

    // 1. Clean power-up
    step_to(3);   chk("t1_rst_hold",  ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(4);   chk("t1_rst_end",   ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(13);  chk("t1_stable",    ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(14);  chk("t1_rel0",      ev(0, 0, 4'b0001, 0, 0, 2'd0));
    step_to(15);  chk("t1_rel0_hold", ev(0, 0, 4'b0001, 0, 0, 2'd0));
    step_to(16);  chk("t1_rel1",      ev(0, 0, 4'b0011, 0, 0, 2'd0));
    step_to(18);  chk("t1_rel2",      ev(0, 0, 4'b0111, 0, 0, 2'd0));
    step_to(20);  chk("t1_rel3",      ev(0, 0, 4'b1111, 0, 0, 2'd0));
    step_to(21);  chk("t1_run",       ev(0, 0, 4'b1111, 1, 0, 2'd0));

    // 4. Lock loss in RUN
    step_to(22);  ifc.pll_extlock = 1'b0;
    step_to(24);  chk("t4_still_run", ev(0, 0, 4'b1111, 1, 0, 2'd0));
    step_to(25);  chk("t4_drop",      ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(28);  chk("t4_rst_hold",  ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(29);  chk("t4_rst_end",   ev(0, 0, 4'b0000, 0, 0, 2'd0));
    ifc.pll_extlock = 1'b1;
    step_to(40);  chk("t4_stable",    ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(41);  chk("t4_rel0",      ev(0, 0, 4'b0001, 0, 0, 2'd0));
    step_to(47);  chk("t4_rel3",      ev(0, 0, 4'b1111, 0, 0, 2'd0));
    step_to(48);  chk("t4_run",       ev(0, 0, 4'b1111, 1, 0, 2'd0));

    // 5. Standby wins over simultaneous lock loss
    ifc.sleep_req   = 1'b1;
    ifc.pll_extlock = 1'b0;
    step_to(49);  chk("t5_stdby",     ev(0, 1, 4'b0000, 0, 0, 2'd0));
    step_to(50);  ifc.pll_extlock = 1'b1;
    step_to(58);  chk("t5_stdby_hold", ev(0, 1, 4'b0000, 0, 0, 2'd0));
    ifc.sleep_req = 1'b0;
    step_to(59);  chk("t5_wake_rst",  ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(62);  chk("t5_rst_hold",  ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(63);  chk("t5_rst_end",   ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(72);  chk("t5_stable",    ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(73);  chk("t5_rel0",      ev(0, 0, 4'b0001, 0, 0, 2'd0));
    step_to(80);  chk("t5_run",       ev(0, 0, 4'b1111, 1, 0, 2'd0));

    // 2. Lock never comes: three attempts then FAULT
    ifc.pll_extlock = 1'b0;
    step_to(86);  chk("t2_a1_hold",   ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(87);  chk("t2_a1_wait",   ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(106); chk("t2_a1_last",   ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(107); chk("t2_retry1",    ev(1, 0, 4'b0000, 0, 0, 2'd1));
    step_to(110); chk("t2_a2_hold",   ev(1, 0, 4'b0000, 0, 0, 2'd1));
    step_to(111); chk("t2_a2_wait",   ev(0, 0, 4'b0000, 0, 0, 2'd1));
    step_to(130); chk("t2_a2_last",   ev(0, 0, 4'b0000, 0, 0, 2'd1));
    step_to(131); chk("t2_retry2",    ev(1, 0, 4'b0000, 0, 0, 2'd2));
    step_to(135); chk("t2_a3_wait",   ev(0, 0, 4'b0000, 0, 0, 2'd2));
    step_to(154); chk("t2_a3_last",   ev(0, 0, 4'b0000, 0, 0, 2'd2));
    step_to(155); chk("t2_fault",     ev(1, 0, 4'b0000, 0, 1, 2'd3));
    ifc.sleep_req = 1'b1;
    step_to(160); chk("t2_fault_sticky", ev(1, 0, 4'b0000, 0, 1, 2'd3));
    ifc.sleep_req = 1'b0;
    step_to(165); ifc.clear_fault = 1'b1;
    step_to(166); ifc.clear_fault = 1'b0;
    chk("t2_cleared",   ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(169); chk("t2_new_hold",  ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(170); chk("t2_new_wait",  ev(0, 0, 4'b0000, 0, 0, 2'd0));

    // 3. One-cycle lock glitch during STABLE
    ifc.pll_extlock = 1'b1;
    step_to(178); ifc.pll_extlock = 1'b0;
    step_to(179); ifc.pll_extlock = 1'b1;
    step_to(182); chk("t3_no_early_rel", ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(190); chk("t3_restarted",    ev(0, 0, 4'b0000, 0, 0, 2'd0));
    step_to(191); chk("t3_rel0",         ev(0, 0, 4'b0001, 0, 0, 2'd0));

    // 6. Async reset mid-RELEASE
    step_to(193); chk("t6_rel1",      ev(0, 0, 4'b0011, 0, 0, 2'd0));
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rst", ev(1, 0, 4'b0000, 0, 0, 2'd0));
    step_to(195); chk("t6_rst_held",  ev(1, 0, 4'b0000, 0, 0, 2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
